// File: rtl/alu_issue32_if.sv
// ============================================================================
// Module      : alu_issue32_if
// Description : Instruction-in / ALU-operation-out handshake bundle for the
//               alu_issue32 issue stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_issue32_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  alu_ctrl;
    logic [4:0]  out_rd;
    logic        out_illegal;

    // The issue stage itself
    modport slave (
        input  in_valid, in_instr, in_rs1_data, in_rs2_data, out_ready,
        output in_ready, out_valid, rs1, rs2, alu_ctrl, out_rd, out_illegal
    );

    // Upstream producer plus downstream ALU
    modport master (
        output in_valid, in_instr, in_rs1_data, in_rs2_data, out_ready,
        input  in_ready, out_valid, rs1, rs2, alu_ctrl, out_rd, out_illegal
    );
endinterface

`default_nettype wire

// File: rtl/alu_issue32.sv
// ============================================================================
// Module      : alu_issue32
// Description : RV32I ALU-instruction decode and issue stage with a
//               valid/ready output register; ALU_ISSUE_SKID_EN adds a skid slot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue32 (
    input  wire logic   clk,
    input  wire logic   rst,
    alu_issue32_if.slave bus
);

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_F7_BASE    = 7'b0000000;
    localparam logic [6:0] c_F7_ALT     = 7'b0100000;

    localparam logic [3:0] c_ALU_ADD  = 4'b0000;
    localparam logic [3:0] c_ALU_SUB  = 4'b0001;
    localparam logic [3:0] c_ALU_AND  = 4'b0010;
    localparam logic [3:0] c_ALU_OR   = 4'b0011;
    localparam logic [3:0] c_ALU_XOR  = 4'b0100;
    localparam logic [3:0] c_ALU_SLL  = 4'b0101;
    localparam logic [3:0] c_ALU_SRL  = 4'b0110;
    localparam logic [3:0] c_ALU_SRA  = 4'b0111;
    localparam logic [3:0] c_ALU_SLT  = 4'b1000;
    localparam logic [3:0] c_ALU_SLTU = 4'b1001;

    // Record layout: {illegal, rd, alu_ctrl, operand B, operand A}
    localparam int c_REC_W = 1 + 5 + 4 + 32 + 32;

    logic [6:0]         w_opcode;
    logic [2:0]         w_funct3;
    logic [6:0]         w_funct7;
    logic [31:0]        w_op_a;
    logic [31:0]        w_op_b;
    logic [3:0]         w_ctrl;
    logic               w_illegal;
    logic [c_REC_W-1:0] w_dec_rec;

    logic               r_out_valid;
    logic [c_REC_W-1:0] r_out_rec;
    logic               w_push;

    assign w_opcode = bus.in_instr[6:0];
    assign w_funct3 = bus.in_instr[14:12];
    assign w_funct7 = bus.in_instr[31:25];

    always_comb begin
        w_illegal = 1'b0;
        w_ctrl    = c_ALU_ADD;
        w_op_a    = bus.in_rs1_data;
        w_op_b    = bus.in_rs2_data;
        case (w_opcode)
            c_OPC_OP: begin
                if (w_funct7 == c_F7_BASE) begin
                    case (w_funct3)
                        3'b000: w_ctrl = c_ALU_ADD;
                        3'b001: w_ctrl = c_ALU_SLL;
                        3'b010: w_ctrl = c_ALU_SLT;
                        3'b011: w_ctrl = c_ALU_SLTU;
                        3'b100: w_ctrl = c_ALU_XOR;
                        3'b101: w_ctrl = c_ALU_SRL;
                        3'b110: w_ctrl = c_ALU_OR;
                        3'b111: w_ctrl = c_ALU_AND;
                    endcase
                end else if (w_funct7 == c_F7_ALT && w_funct3 == 3'b000) begin
                    w_ctrl = c_ALU_SUB;
                end else if (w_funct7 == c_F7_ALT && w_funct3 == 3'b101) begin
                    w_ctrl = c_ALU_SRA;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            c_OPC_OP_IMM: begin
                w_op_b = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
                case (w_funct3)
                    3'b000: w_ctrl = c_ALU_ADD;
                    3'b001: begin
                        w_op_b = {27'b0, bus.in_instr[24:20]};
                        w_ctrl = c_ALU_SLL;
                        if (w_funct7 != c_F7_BASE) w_illegal = 1'b1;
                    end
                    3'b010: w_ctrl = c_ALU_SLT;
                    3'b011: w_ctrl = c_ALU_SLTU;
                    3'b100: w_ctrl = c_ALU_XOR;
                    3'b101: begin
                        w_op_b = {27'b0, bus.in_instr[24:20]};
                        if (w_funct7 == c_F7_BASE)     w_ctrl = c_ALU_SRL;
                        else if (w_funct7 == c_F7_ALT) w_ctrl = c_ALU_SRA;
                        else                           w_illegal = 1'b1;
                    end
                    3'b110: w_ctrl = c_ALU_OR;
                    3'b111: w_ctrl = c_ALU_AND;
                endcase
            end
            c_OPC_LUI: begin
                w_op_a = 32'b0;
                w_op_b = {bus.in_instr[31:12], 12'b0};
            end
            default: w_illegal = 1'b1;
        endcase
        // Illegal words still flow downstream, but carry no operands
        if (w_illegal) begin
            w_ctrl = c_ALU_ADD;
            w_op_a = 32'b0;
            w_op_b = 32'b0;
        end
    end

    assign w_dec_rec = {w_illegal, bus.in_instr[11:7], w_ctrl, w_op_b, w_op_a};

`ifdef ALU_ISSUE_SKID_EN
    logic               r_in_ready;
    logic               r_skid_valid;
    logic [c_REC_W-1:0] r_skid_rec;
    logic               w_pop;
    logic [1:0]         w_count;
    logic [1:0]         w_count_nxt;

    assign bus.in_ready = r_in_ready;
    assign w_push       = bus.in_valid && r_in_ready;
    assign w_pop        = r_out_valid && bus.out_ready;
    assign w_count      = {1'b0, r_out_valid} + {1'b0, r_skid_valid};
    assign w_count_nxt  = w_count + {1'b0, w_push} - {1'b0, w_pop};

    // in_ready is precomputed from next occupancy so out_ready never reaches it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_rec    <= '0;
            r_skid_valid <= 1'b0;
            r_skid_rec   <= '0;
        end else begin
            r_in_ready <= (w_count_nxt < 2'd2);
            if (!r_out_valid || w_pop) begin
                if (r_skid_valid) begin
                    r_out_valid <= 1'b1;
                    r_out_rec   <= r_skid_rec;
                    if (w_push) r_skid_rec   <= w_dec_rec;
                    else        r_skid_valid <= 1'b0;
                end else if (w_push) begin
                    r_out_valid <= 1'b1;
                    r_out_rec   <= w_dec_rec;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_push) begin
                r_skid_valid <= 1'b1;
                r_skid_rec   <= w_dec_rec;
            end
        end
    end
`else
    assign bus.in_ready = !r_out_valid || bus.out_ready;
    assign w_push       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_rec   <= '0;
        end else if (w_push) begin
            r_out_valid <= 1'b1;
            r_out_rec   <= w_dec_rec;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
`endif

    assign bus.out_valid   = r_out_valid;
    assign bus.rs1         = r_out_rec[31:0];
    assign bus.rs2         = r_out_rec[63:32];
    assign bus.alu_ctrl    = r_out_rec[67:64];
    assign bus.out_rd      = r_out_rec[72:68];
    assign bus.out_illegal = r_out_rec[73];

endmodule

`default_nettype wire

// File: tb/tb_alu_issue32.sv
// ============================================================================
// Module      : tb_alu_issue32
// Description : Directed vector-table bench for alu_issue32 (both build modes).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue32;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] a_data;
        logic [31:0] b_data;
        logic [31:0] exp_rs1;
        logic [31:0] exp_rs2;
        logic [3:0]  exp_ctrl;
        logic [4:0]  exp_rd;
        logic        exp_ill;
    } vec_t;

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        ill;
    } out_t;

    localparam int c_NVEC = 17;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    vec_t vecs[c_NVEC];
    out_t got[$];
    out_t snap;
    logic prev_stall;

    alu_issue32_if bus();

    alu_issue32 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input vec_t v);
        chk({tag, " out_valid"}, {31'b0, bus.out_valid}, 32'd1);
        chk({tag, " rs1"}, bus.rs1, v.exp_rs1);
        chk({tag, " rs2"}, bus.rs2, v.exp_rs2);
        chk({tag, " alu_ctrl"}, {28'b0, bus.alu_ctrl}, {28'b0, v.exp_ctrl});
        chk({tag, " out_rd"}, {27'b0, bus.out_rd}, {27'b0, v.exp_rd});
        chk({tag, " out_illegal"}, {31'b0, bus.out_illegal}, {31'b0, v.exp_ill});
    endtask

    task automatic drive(input vec_t v);
        bus.in_instr    = v.instr;
        bus.in_rs1_data = v.a_data;
        bus.in_rs2_data = v.b_data;
    endtask

    // Offer one vector and hold it until the block takes it; returns at edge+2
    task automatic send(input int idx);
        logic w;
        int   tries;
        bit   acc;
        drive(vecs[idx]);
        bus.in_valid = 1'b1;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 30) begin
            @(negedge clk);
            w = bus.in_ready;
            @(posedge clk);
            #2;
            acc = w;
            tries++;
        end
        bus.in_valid = 1'b0;
        if (!acc) chk($sformatf("send%0d accepted", idx), 32'd0, 32'd1);
    endtask

    // Downstream observer: capture transfers and check stalled outputs hold
    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else if (bus.out_valid && !bus.out_ready) begin
            if (prev_stall) begin
                chk("stall rs1", bus.rs1, snap.rs1);
                chk("stall rs2", bus.rs2, snap.rs2);
                chk("stall ctrl_rd_ill", {23'b0, bus.alu_ctrl, bus.out_rd, bus.out_illegal},
                    {23'b0, snap.ctrl, snap.rd, snap.ill});
            end
            snap       <= '{bus.rs1, bus.rs2, bus.alu_ctrl, bus.out_rd, bus.out_illegal};
            prev_stall <= 1'b1;
        end else begin
            prev_stall <= 1'b0;
            if (bus.out_valid && bus.out_ready)
                got.push_back('{bus.rs1, bus.rs2, bus.alu_ctrl, bus.out_rd, bus.out_illegal});
        end
    end

    initial begin
        int n_acc;
        int exp_acc;
        errors = 0;
        checks = 0;
        prev_stall = 1'b0;

        //             instr         a_data        b_data        rs1           rs2           ctrl   rd     ill
        vecs[0]  = '{32'h40B50533, 32'd10,       32'd3,        32'd10,       32'd3,        4'h1,  5'd10, 1'b0};
        vecs[1]  = '{32'hFFF00093, 32'd0,        32'h5,        32'd0,        32'hFFFFFFFF, 4'h0,  5'd1,  1'b0};
        vecs[2]  = '{32'h4010D093, 32'h80000000, 32'h7,        32'h80000000, 32'd1,        4'h7,  5'd1,  1'b0};
        vecs[3]  = '{32'h12345037, 32'hDEAD,     32'hBEEF,     32'd0,        32'h12345000, 4'h0,  5'd0,  1'b0};
        vecs[4]  = '{32'h00000073, 32'd7,        32'd9,        32'd0,        32'd0,        4'h0,  5'd0,  1'b1};
        vecs[5]  = '{32'h002081B3, 32'h11,       32'h22,       32'h11,       32'h22,       4'h0,  5'd3,  1'b0};
        vecs[6]  = '{32'h007372B3, 32'hF0F0,     32'h0FF0,     32'hF0F0,     32'h0FF0,     4'h2,  5'd5,  1'b0};
        vecs[7]  = '{32'h407372B3, 32'h1,        32'h2,        32'd0,        32'd0,        4'h0,  5'd5,  1'b1};
        vecs[8]  = '{32'h01F11093, 32'h3,        32'h4,        32'h3,        32'd31,       4'h5,  5'd1,  1'b0};
        vecs[9]  = '{32'h03F11093, 32'h3,        32'h4,        32'd0,        32'd0,        4'h0,  5'd1,  1'b1};
        vecs[10] = '{32'h80023213, 32'h44,       32'h0,        32'h44,       32'hFFFFF800, 4'h9,  5'd4,  1'b0};
        vecs[11] = '{32'h0020A4B3, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd1,        4'h8,  5'd9,  1'b0};
        vecs[12] = '{32'h0020D4B3, 32'h100,      32'd4,        32'h100,      32'd4,        4'h6,  5'd9,  1'b0};
        vecs[13] = '{32'h7FF0C113, 32'h1234,     32'h0,        32'h1234,     32'h7FF,      4'h4,  5'd2,  1'b0};
        vecs[14] = '{32'h0010E113, 32'h8,        32'h0,        32'h8,        32'd1,        4'h3,  5'd2,  1'b0};
        vecs[15] = '{32'h002094B3, 32'h1,        32'd5,        32'h1,        32'd5,        4'h5,  5'd9,  1'b0};
        vecs[16] = '{32'h4020D4B3, 32'h80000000, 32'd2,        32'h80000000, 32'd2,        4'h7,  5'd9,  1'b0};

        // Reset held two cycles with a valid instruction presented
        rst           = 1'b1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        drive(vecs[0]);
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst out_illegal", {31'b0, bus.out_illegal}, 32'd0);
        chk("rst rs1", bus.rs1, 32'd0);
        chk("rst rs2", bus.rs2, 32'd0);
        chk("rst alu_ctrl", {28'b0, bus.alu_ctrl}, 32'd0);
        chk("rst out_rd", {27'b0, bus.out_rd}, 32'd0);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        chk("post-rst in_ready", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("post-rst out_valid", {31'b0, bus.out_valid}, 32'd0);

        // Back-to-back stream, downstream always ready
        bus.out_ready = 1'b1;
        drive(vecs[0]);
        bus.in_valid = 1'b1;
        for (int i = 0; i < c_NVEC; i++) begin
            @(posedge clk);
            #1;
            chk_out($sformatf("vec%0d", i), vecs[i]);
            if (i + 1 < c_NVEC) drive(vecs[i + 1]);
            else                bus.in_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("drain out_valid", {31'b0, bus.out_valid}, 32'd0);

        // Back-pressure: four instructions against a three-cycle stall
`ifdef ALU_ISSUE_SKID_EN
        exp_acc = 2;
`else
        exp_acc = 1;
`endif
        got.delete();
        n_acc = 0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #2;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    send(4 + k);
                    n_acc++;
                end
            end
            begin
                repeat (4) @(posedge clk);
                #3;
                chk("bp accepted while stalled", n_acc, exp_acc);
                chk("bp in_ready while stalled", {31'b0, bus.in_ready}, 32'd0);
                bus.out_ready = 1'b1;
                for (int t = 0; t < 40 && got.size() < 4; t++) @(posedge clk);
            end
        join
        chk("bp delivered count", got.size(), 32'd4);
        for (int k = 0; k < 4 && k < got.size(); k++) begin
            chk($sformatf("bp%0d rs1", k), got[k].rs1, vecs[4 + k].exp_rs1);
            chk($sformatf("bp%0d rs2", k), got[k].rs2, vecs[4 + k].exp_rs2);
            chk($sformatf("bp%0d ctrl_rd_ill", k), {23'b0, got[k].ctrl, got[k].rd, got[k].ill},
                {23'b0, vecs[4 + k].exp_ctrl, vecs[4 + k].exp_rd, vecs[4 + k].exp_ill});
        end
        repeat (2) @(posedge clk);

        // Reset while entries are buffered: they must never be emitted
        bus.out_ready = 1'b0;
        #2;
        send(5);
`ifdef ALU_ISSUE_SKID_EN
        send(6);
`endif
        got.delete();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst2 out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst2 rs1", bus.rs1, 32'd0);
        chk("rst2 rs2", bus.rs2, 32'd0);
        chk("rst2 ctrl_rd_ill", {23'b0, bus.alu_ctrl, bus.out_rd, bus.out_illegal}, 32'd0);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst2 nothing emitted", got.size(), 32'd0);
        chk("rst2 in_ready", {31'b0, bus.in_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
